// File: rtl/traffic_pkg.sv
// Shared encodings, default durations and timer states for the traffic light front end.
// No logic; constants only.
// Imported by the request/timer stage and the light controller.
package traffic_pkg;

    localparam logic [1:0] TSEL_GRN = 2'b00;
    localparam logic [1:0] TSEL_YEL = 2'b01;
    localparam logic [1:0] TSEL_PED = 2'b10;
    localparam logic [1:0] TSEL_SEC = 2'b11;

    localparam int DEF_TICK_DIV = 50000000;
    localparam int DEF_G_SEC    = 10;
    localparam int DEF_Y_SEC    = 3;
    localparam int DEF_PED_SEC  = 8;
    localparam int DEF_SEC_SEC  = 6;
    localparam int DEF_EXT_SEC  = 2;
    localparam int DEF_MAX_SEC  = 20;

    localparam logic [0:0] TMR_IDLE = 1'b0;
    localparam logic [0:0] TMR_RUN  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = TMR_IDLE,
        ST_RUN  = TMR_RUN
    } tmr_state_e;

endpackage

// File: rtl/sync_edge.sv
// 2-flop synchroniser followed by a registered rising-edge pulse.
// Latency: input rise sampled at edge k gives rise=1 after edge k+2.
// No backpressure; a held level yields a single pulse.
module sync_edge (
    input  logic Clock,
    input  logic Resetn,
    input  logic din,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/traffic_req_timer.sv
// Request conditioning and seconds-based phase timer feeding the light controller.
// Latency: raw request to s_req/p_req is 3 edges; expiry pulse registered with secs_left=0.
// No backpressure; clears and tmr_start are single-cycle strobes from the controller.
module traffic_req_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int G_SEC    = DEF_G_SEC,
    parameter int Y_SEC    = DEF_Y_SEC,
    parameter int PED_SEC  = DEF_PED_SEC,
    parameter int SEC_SEC  = DEF_SEC_SEC,
    parameter int EXT_SEC  = DEF_EXT_SEC,
    parameter int MAX_SEC  = DEF_MAX_SEC
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       S_in,
    input  logic       P_in,
    input  logic       C_in,
    input  logic       clr_s,
    input  logic       clr_p,
    input  logic       tmr_start,
    input  logic [1:0] tmr_sel,
    output logic       s_req,
    output logic       p_req,
    output logic       prefer_sec,
    output logic       t_sec,
    output logic       t_yellow,
    output logic       busy,
    output logic [5:0] secs_left
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic s_rise;
    logic p_rise;
    logic c_rise;

    sync_edge u_sync_s (.Clock(Clock), .Resetn(Resetn), .din(S_in), .rise(s_rise));
    sync_edge u_sync_p (.Clock(Clock), .Resetn(Resetn), .din(P_in), .rise(p_rise));
    sync_edge u_sync_c (.Clock(Clock), .Resetn(Resetn), .din(C_in), .rise(c_rise));

    // A new press in the same cycle as its clear must survive.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            s_req      <= 1'b0;
            p_req      <= 1'b0;
            prefer_sec <= 1'b1;
        end else begin
            s_req <= s_rise | (s_req & ~clr_s);
            p_req <= p_rise | (p_req & ~clr_p);
            if (clr_s && !clr_p) begin
                prefer_sec <= 1'b0;
            end else if (clr_p && !clr_s) begin
                prefer_sec <= 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == CNT_MAX);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pre_cnt <= '0;
        end else if (tmr_start || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    logic [5:0] sel_dur;

    always_comb begin
        sel_dur = 6'(G_SEC);
        case (tmr_sel)
            TSEL_GRN: sel_dur = 6'(G_SEC);
            TSEL_YEL: sel_dur = 6'(Y_SEC);
            TSEL_PED: sel_dur = 6'(PED_SEC);
            TSEL_SEC: sel_dur = 6'(SEC_SEC);
            default:  sel_dur = 6'(G_SEC);
        endcase
    end

    // secs_left >= 1 while running, so the 7-bit sum never underflows.
    logic [6:0] ext_sum;
    logic [5:0] ext_val;

    assign ext_sum = {1'b0, secs_left} - {6'd0, tick} + 7'(EXT_SEC);
    assign ext_val = (ext_sum > 7'(MAX_SEC)) ? 6'(MAX_SEC) : ext_sum[5:0];

    logic [0:0] state;
    logic [1:0] sel_q;

    assign busy = (state == TMR_RUN);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= TMR_IDLE;
            sel_q     <= TSEL_GRN;
            secs_left <= '0;
            t_sec     <= 1'b0;
            t_yellow  <= 1'b0;
        end else begin
            t_sec    <= 1'b0;
            t_yellow <= 1'b0;
            if (tmr_start) begin
                state     <= TMR_RUN;
                sel_q     <= tmr_sel;
                secs_left <= sel_dur;
            end else if (state == TMR_RUN) begin
                if (sel_q == TSEL_SEC && c_rise) begin
                    secs_left <= ext_val;
                end else if (tick) begin
                    secs_left <= secs_left - 6'd1;
                    if (secs_left == 6'd1) begin
                        state <= TMR_IDLE;
                        if (sel_q == TSEL_YEL) begin
                            t_yellow <= 1'b1;
                        end else begin
                            t_sec <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_req_timer.sv
// Randomised and directed bench for traffic_req_timer against an edge-indexed reference model.
module tb_traffic_req_timer;

    localparam int TDIV = 4;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       S_in = 1'b0;
    logic       P_in = 1'b0;
    logic       C_in = 1'b0;
    logic       clr_s = 1'b0;
    logic       clr_p = 1'b0;
    logic       tmr_start = 1'b0;
    logic [1:0] tmr_sel = 2'b00;
    logic       s_req;
    logic       p_req;
    logic       prefer_sec;
    logic       t_sec;
    logic       t_yellow;
    logic       busy;
    logic [5:0] secs_left;

    traffic_req_timer #(.TICK_DIV(TDIV)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .S_in(S_in), .P_in(P_in), .C_in(C_in),
        .clr_s(clr_s), .clr_p(clr_p),
        .tmr_start(tmr_start), .tmr_sel(tmr_sel),
        .s_req(s_req), .p_req(p_req), .prefer_sec(prefer_sec),
        .t_sec(t_sec), .t_yellow(t_yellow), .busy(busy), .secs_left(secs_left)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge number n counts rising edges since reset release.
    int n;
    int t0;
    bit qs[$];
    bit qp[$];
    bit qc[$];
    bit m_s, m_p, m_pref, m_run, m_tsec, m_tyel;
    int m_secs;
    int m_sel;

    function automatic int dur(input int sel);
        case (sel)
            0: return 10;
            1: return 3;
            2: return 8;
            default: return 6;
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        t0 = 0;
        qs.delete(); qp.delete(); qc.delete();
        for (int i = 0; i < 4; i++) begin
            qs.push_back(1'b0); qp.push_back(1'b0); qc.push_back(1'b0);
        end
        m_s = 0; m_p = 0; m_pref = 1; m_run = 0; m_tsec = 0; m_tyel = 0;
        m_secs = 0; m_sel = 0;
    endtask

    // Event at edge n is a rise between raw samples taken at edges n-4 and n-3.
    function automatic bit rise_of(input bit q[$]);
        int sz = q.size();
        return q[sz-4] && !q[sz-5];
    endfunction

    task automatic model_edge();
        bit es, ep, ec, tk;
        n++;
        qs.push_back(S_in); qp.push_back(P_in); qc.push_back(C_in);
        es = rise_of(qs); ep = rise_of(qp); ec = rise_of(qc);
        if (qs.size() > 8) begin
            void'(qs.pop_front()); void'(qp.pop_front()); void'(qc.pop_front());
        end
        tk = ((n - t0) % TDIV) == 0;
        m_s = es | (m_s & !clr_s);
        m_p = ep | (m_p & !clr_p);
        if (clr_s && !clr_p) m_pref = 0;
        else if (clr_p && !clr_s) m_pref = 1;
        m_tsec = 0;
        m_tyel = 0;
        if (tmr_start) begin
            m_run = 1;
            m_sel = int'(tmr_sel);
            m_secs = dur(m_sel);
            t0 = n;
        end else if (m_run) begin
            if (m_sel == 3 && ec) begin
                m_secs = m_secs - int'(tk) + 2;
                if (m_secs > 20) m_secs = 20;
            end else if (tk) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_run = 0;
                    if (m_sel == 1) m_tyel = 1;
                    else m_tsec = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        chk("outputs", {s_req, p_req, prefer_sec, t_sec, t_yellow, busy, secs_left},
            {m_s, m_p, m_pref, m_tsec, m_tyel, m_run, 6'(m_secs)});
        clr_s = 0;
        clr_p = 0;
        tmr_start = 0;
    endtask

    task automatic do_reset();
        Resetn = 0;
        #1;
        chk("rst_async", {4'd0, t_sec, t_yellow, busy, prefer_sec, 2'd0, secs_left[1:0]},
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0});
        chk("rst_secs", {6'd0, secs_left}, 12'd0);
        @(posedge Clock);
        @(negedge Clock);
        Resetn = 1;
        model_reset();
    endtask

    int max_seen;

    initial begin
        model_reset();
        @(negedge Clock);
        do_reset();

        // Idle after reset.
        repeat (100) step();

        // Single-cycle pedestrian pulse, then held button with a clear.
        P_in = 1; step();
        P_in = 0; repeat (3) step();
        chk("p_pulse", {11'd0, p_req}, 12'd1);
        P_in = 1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) clr_p = 1;
            step();
        end
        chk("p_held_clr", {11'd0, p_req}, 12'd0);
        P_in = 0; repeat (4) step();

        // Yellow timer: expiry pulse 12 edges after start.
        tmr_sel = 2'b01; tmr_start = 1; step();
        repeat (11) step();
        chk("yel_pre", {10'd0, t_yellow, busy}, 12'd1);
        step();
        chk("yel_exp", {4'd0, t_sec, t_yellow, busy, 5'd0}, {4'd0, 1'b0, 1'b1, 1'b0, 5'd0});
        repeat (3) step();

        // Car edge coincident with the 1->0 tick extends to 2 with no expiry.
        C_in = 0; repeat (4) step();
        tmr_sel = 2'b11; tmr_start = 1; step();
        for (int i = 1; i <= 24; i++) begin
            C_in = (i >= 21);
            step();
        end
        chk("ext_coinc", {5'd0, t_sec, secs_left}, {5'd0, 1'b0, 6'd2});

        // Repeated car edges saturate at the ceiling.
        max_seen = 0;
        for (int i = 0; i < 40; i++) begin
            C_in = ~C_in;
            step();
            if (int'(secs_left) > max_seen) max_seen = int'(secs_left);
        end
        chk("ext_sat", 12'(max_seen), 12'd20);
        C_in = 0;

        // Clear and new press on the same edge.
        S_in = 1; P_in = 1; step();
        S_in = 0; P_in = 0; repeat (4) step();
        chk("both_req", {10'd0, s_req, p_req}, 12'd3);
        P_in = 1; repeat (3) step();
        clr_s = 1; step();
        chk("clr_s_pedge", {9'd0, s_req, p_req, prefer_sec}, {9'd0, 1'b0, 1'b1, 1'b0});
        P_in = 0; repeat (2) step();
        P_in = 1; repeat (3) step();
        clr_p = 1; step();
        chk("clr_p_pedge", {10'd0, p_req, prefer_sec}, 12'd3);
        P_in = 0;

        // Restart at secs_left=1 abandons the yellow run.
        repeat (30) step();
        tmr_sel = 2'b01; tmr_start = 1; step();
        repeat (9) step();
        chk("restart_pre", {6'd0, secs_left}, 12'd1);
        tmr_sel = 2'b00; tmr_start = 1; step();
        chk("restart", {4'd0, t_sec, t_yellow, secs_left}, {4'd0, 1'b0, 1'b0, 6'd10});
        repeat (3) step();

        // Reset in the middle of a run.
        do_reset();
        repeat (60) step();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(9) == 0) S_in = ~S_in;
            if ($urandom_range(9) == 0) P_in = ~P_in;
            if ($urandom_range(2) == 0) C_in = ~C_in;
            clr_s = ($urandom_range(5) == 0);
            clr_p = ($urandom_range(5) == 0);
            tmr_start = ($urandom_range(29) == 0);
            tmr_sel = 2'($urandom_range(3));
            if (i == 1200) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
